// File: rtl/delay_sweep_pkg.sv
// delay_sweep_pkg
//   Shared definitions for the delay-line sweep controller:
//   - state_e     : sequencer FSM states
//   - REG_*       : Wishbone register word offsets (byte address bits [4:2])
//   - CTRL_*/STAT_*: bit positions inside the CTRL and STATUS registers
package delay_sweep_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETTLE = 3'd1,
    ST_STB_HI = 3'd2,
    ST_STB_LO = 3'd3,
    ST_NEXT   = 3'd4,
    ST_DONE   = 3'd5
  } state_e;

  localparam logic [2:0] REG_CTRL       = 3'd0;
  localparam logic [2:0] REG_START_CODE = 3'd1;
  localparam logic [2:0] REG_STOP_STEP  = 3'd2;
  localparam logic [2:0] REG_REPS       = 3'd3;
  localparam logic [2:0] REG_STATUS     = 3'd4;
  localparam logic [2:0] REG_RESULT     = 3'd5;
  localparam logic [2:0] REG_HITS       = 3'd6;

  localparam int CTRL_START_BIT  = 0;
  localparam int CTRL_ABORT_BIT  = 1;
  localparam int CTRL_IRQ_EN_BIT = 2;

  localparam int STAT_BUSY_BIT  = 0;
  localparam int STAT_DONE_BIT  = 1;
  localparam int STAT_FOUND_BIT = 2;
  localparam int STAT_CODE_LSB  = 16;

  localparam int STEP_LSB = 16;

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff
//   Generic two-flop synchronizer for asynchronous level inputs.
//   Ports:
//     clk_i  : destination clock
//     srst_i : synchronous active-high reset (clears both stages)
//     d_i    : asynchronous input, WIDTH bits (bits are independent)
//     q_o    : synchronized output, two clocks of latency
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             srst_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/delay_sweep_ctrl.sv
// delay_sweep_ctrl
//   Wishbone-slave sequencer for delay-line threshold scans. Steps the delay
//   code from START_CODE towards STOP_CODE by STEP, strobes the delay line
//   REPS times per code, counts synchronized comparator hits and records the
//   first code whose hit count reaches majority (2*hits >= REPS).
//   Ports:
//     wb_clk_i, wb_rst_i     : clock, synchronous active-high reset
//     wb_adr_i/dat_i/we_i/sel_i/cyc_i/stb_i : Wishbone slave inputs
//     wb_dat_o, wb_ack_o     : registered read data, one-cycle ack
//     wb_stall_o, wb_err_o   : tied low
//     delay_code_o           : code applied to the delay line
//     delay_stb_o            : delay-line strobe
//     cmp_out_i              : asynchronous comparator output
//     irq_o                  : DONE & IRQ_EN, only when DELAY_SWEEP_IRQ_EN is
//                              defined (otherwise no port, IRQ_EN reads 0)
module delay_sweep_ctrl
  import delay_sweep_pkg::*;
#(
  parameter int CODE_W        = 10,
  parameter int CNT_W         = 16,
  parameter int STB_CYCLES    = 3,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic [31:0]       wb_adr_i,
  input  logic [31:0]       wb_dat_i,
  output logic [31:0]       wb_dat_o,
  input  logic              wb_we_i,
  input  logic [3:0]        wb_sel_i,
  input  logic              wb_cyc_i,
  input  logic              wb_stb_i,
  output logic              wb_ack_o,
  output logic              wb_stall_o,
  output logic              wb_err_o,
  output logic [CODE_W-1:0] delay_code_o,
  output logic              delay_stb_o,
  input  logic              cmp_out_i
`ifdef DELAY_SWEEP_IRQ_EN
  ,
  output logic              irq_o
`endif
);

  localparam int PH_W = 8;

  // Bus side
  logic        ack_q, ack_d;
  logic        wr_q, wr_d;
  logic [2:0]  adr_q, adr_d;
  logic [31:0] wdat_q, wdat_d;
  logic [31:0] dat_q, dat_d;
  logic [31:0] rd_data;

  // Software-visible configuration
  logic [CODE_W-1:0] start_code_q, start_code_d;
  logic [CODE_W-1:0] stop_code_q, stop_code_d;
  logic [CODE_W-1:0] step_q, step_d;
  logic [CNT_W-1:0]  reps_q, reps_d;
  logic              irq_en_q, irq_en_d;

  // Working copies captured at START so mid-sweep writes do not disturb it
  logic [CODE_W-1:0] stop_w_q, stop_w_d;
  logic [CODE_W-1:0] step_w_q, step_w_d;
  logic [CNT_W-1:0]  reps_w_q, reps_w_d;

  // Sequencer
  state_e            state_q, state_d;
  logic [PH_W-1:0]   ph_q, ph_d;
  logic [CNT_W-1:0]  rep_q, rep_d;
  logic [CNT_W-1:0]  hit_q, hit_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic [CODE_W-1:0] result_q, result_d;
  logic [CNT_W-1:0]  hits_q, hits_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              found_q, found_d;

  logic              cmp_sync;
  logic              accept;
  logic              wr_en;
  logic              ctrl_wr;
  logic              start_req;
  logic              abort_req;
  logic              done_clr;
  logic              load_sweep;
  logic [CODE_W:0]   next_sum;

  sync_2ff #(
    .WIDTH (1)
  ) u_cmp_sync (
    .clk_i  (wb_clk_i),
    .srst_i (wb_rst_i),
    .d_i    (cmp_out_i),
    .q_o    (cmp_sync)
  );

  // A request is taken only while no ack is outstanding; the write itself is
  // committed during the ack cycle so its effects appear the cycle after ack.
  assign accept    = wb_cyc_i & wb_stb_i & ~ack_q;
  assign wr_en     = ack_q & wr_q;
  assign ctrl_wr   = wr_en && (adr_q == REG_CTRL);
  assign abort_req = ctrl_wr && wdat_q[CTRL_ABORT_BIT];
  assign start_req = ctrl_wr && wdat_q[CTRL_START_BIT] && !wdat_q[CTRL_ABORT_BIT];
  assign done_clr  = wr_en && (adr_q == REG_STATUS) && wdat_q[STAT_DONE_BIT];
  assign load_sweep = start_req && (state_q == ST_IDLE || state_q == ST_DONE);
  assign next_sum  = {1'b0, code_q} + {1'b0, step_w_q};

  always_comb begin
    rd_data = '0;
    case (wb_adr_i[4:2])
      REG_CTRL:       rd_data[CTRL_IRQ_EN_BIT] = irq_en_q;
      REG_START_CODE: rd_data[CODE_W-1:0] = start_code_q;
      REG_STOP_STEP: begin
        rd_data[CODE_W-1:0]         = stop_code_q;
        rd_data[STEP_LSB +: CODE_W] = step_q;
      end
      REG_REPS:       rd_data[CNT_W-1:0] = reps_q;
      REG_STATUS: begin
        rd_data[STAT_BUSY_BIT]             = busy_q;
        rd_data[STAT_DONE_BIT]             = done_q;
        rd_data[STAT_FOUND_BIT]            = found_q;
        rd_data[STAT_CODE_LSB +: CODE_W]   = code_q;
      end
      REG_RESULT:     if (found_q) rd_data[CODE_W-1:0] = result_q;
      REG_HITS:       rd_data[CNT_W-1:0] = hits_q;
      default:        rd_data = '0;
    endcase
  end

  always_comb begin
    ack_d        = accept;
    wr_d         = wr_q;
    adr_d        = adr_q;
    wdat_d       = wdat_q;
    dat_d        = dat_q;
    start_code_d = start_code_q;
    stop_code_d  = stop_code_q;
    step_d       = step_q;
    reps_d       = reps_q;
    irq_en_d     = irq_en_q;
    stop_w_d     = stop_w_q;
    step_w_d     = step_w_q;
    reps_w_d     = reps_w_q;
    state_d      = state_q;
    ph_d         = ph_q;
    rep_d        = rep_q;
    hit_d        = hit_q;
    code_d       = code_q;
    result_d     = result_q;
    hits_d       = hits_q;
    busy_d       = busy_q;
    done_d       = done_q;
    found_d      = found_q;

    if (accept) begin
      wr_d   = wb_we_i;
      adr_d  = wb_adr_i[4:2];
      wdat_d = wb_dat_i;
      dat_d  = rd_data;
    end

    if (wr_en) begin
      case (adr_q)
`ifdef DELAY_SWEEP_IRQ_EN
        REG_CTRL:       irq_en_d = wdat_q[CTRL_IRQ_EN_BIT];
`endif
        REG_START_CODE: start_code_d = wdat_q[CODE_W-1:0];
        REG_STOP_STEP: begin
          stop_code_d = wdat_q[CODE_W-1:0];
          step_d      = wdat_q[STEP_LSB +: CODE_W];
        end
        REG_REPS:       reps_d = wdat_q[CNT_W-1:0];
        default: ;
      endcase
    end
    if (done_clr) done_d = 1'b0;

    case (state_q)
      ST_IDLE: ;
      ST_SETTLE: begin
        if (ph_q == PH_W'(SETTLE_CYCLES - 1)) begin
          ph_d    = '0;
          state_d = ST_STB_HI;
        end else begin
          ph_d = ph_q + 1'b1;
        end
      end
      ST_STB_HI: begin
        if (ph_q == PH_W'(STB_CYCLES - 1)) begin
          ph_d    = '0;
          state_d = ST_STB_LO;
        end else begin
          ph_d = ph_q + 1'b1;
        end
      end
      ST_STB_LO: begin
        if (ph_q == PH_W'(STB_CYCLES - 1)) begin
          ph_d  = '0;
          rep_d = rep_q + 1'b1;
          if (cmp_sync) hit_d = hit_q + 1'b1;
          // Compare the post-increment rep count against REPS.
          if (({1'b0, rep_q} + 1'b1) < {1'b0, reps_w_q}) state_d = ST_STB_HI;
          else                                             state_d = ST_NEXT;
        end else begin
          ph_d = ph_q + 1'b1;
        end
      end
      ST_NEXT: begin
        hits_d = hit_q;
        if (!found_q && ({hit_q, 1'b0} >= {1'b0, reps_w_q})) begin
          found_d  = 1'b1;
          result_d = code_q;
        end
        // Carry out of CODE_W means the next code would wrap: stop here.
        if (next_sum[CODE_W] || (next_sum[CODE_W-1:0] > stop_w_q)) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end else begin
          code_d  = next_sum[CODE_W-1:0];
          rep_d   = '0;
          hit_d   = '0;
          ph_d    = '0;
          state_d = ST_SETTLE;
        end
      end
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase

    if (load_sweep) begin
      code_d   = start_code_q;
      stop_w_d = stop_code_q;
      step_w_d = (step_q == '0) ? {{(CODE_W-1){1'b0}}, 1'b1} : step_q;
      reps_w_d = (reps_q == '0) ? {{(CNT_W-1){1'b0}}, 1'b1} : reps_q;
      found_d  = 1'b0;
      result_d = '0;
      ph_d     = '0;
      rep_d    = '0;
      hit_d    = '0;
      busy_d   = 1'b1;
      state_d  = ST_SETTLE;
    end

    // Abort leaves FOUND/RESULT/HITS as they stand and never raises DONE.
    if (abort_req) begin
      state_d = ST_IDLE;
      busy_d  = 1'b0;
      done_d  = done_q & ~done_clr;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      ack_q        <= 1'b0;
      wr_q         <= 1'b0;
      adr_q        <= '0;
      wdat_q       <= '0;
      dat_q        <= '0;
      start_code_q <= '0;
      stop_code_q  <= '0;
      step_q       <= '0;
      reps_q       <= '0;
      irq_en_q     <= 1'b0;
      stop_w_q     <= '0;
      step_w_q     <= '0;
      reps_w_q     <= '0;
      state_q      <= ST_IDLE;
      ph_q         <= '0;
      rep_q        <= '0;
      hit_q        <= '0;
      code_q       <= '0;
      result_q     <= '0;
      hits_q       <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      found_q      <= 1'b0;
    end else begin
      ack_q        <= ack_d;
      wr_q         <= wr_d;
      adr_q        <= adr_d;
      wdat_q       <= wdat_d;
      dat_q        <= dat_d;
      start_code_q <= start_code_d;
      stop_code_q  <= stop_code_d;
      step_q       <= step_d;
      reps_q       <= reps_d;
      irq_en_q     <= irq_en_d;
      stop_w_q     <= stop_w_d;
      step_w_q     <= step_w_d;
      reps_w_q     <= reps_w_d;
      state_q      <= state_d;
      ph_q         <= ph_d;
      rep_q        <= rep_d;
      hit_q        <= hit_d;
      code_q       <= code_d;
      result_q     <= result_d;
      hits_q       <= hits_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      found_q      <= found_d;
    end
  end

  assign wb_ack_o     = ack_q;
  assign wb_dat_o     = dat_q;
  assign wb_stall_o   = 1'b0;
  assign wb_err_o     = 1'b0;
  assign delay_code_o = code_q;
  assign delay_stb_o  = (state_q == ST_STB_HI);

`ifdef DELAY_SWEEP_IRQ_EN
  assign irq_o = done_q & irq_en_q;
`endif

  // Byte lanes and undecoded address bits are intentionally ignored.
  logic unused_bits;
  assign unused_bits = ^{wb_sel_i, wb_adr_i, wdat_q};

endmodule

// File: tb/tb_delay_sweep_ctrl.sv
module tb_delay_sweep_ctrl;
  import delay_sweep_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] adr = '0;
  logic [31:0] dat_i = '0;
  logic [31:0] dat_o;
  logic        we = 1'b0;
  logic [3:0]  sel = 4'hF;
  logic        cyc = 1'b0;
  logic        stb = 1'b0;
  logic        ack, stall, err;
  logic [9:0]  code;
  logic        dstb;
  logic        cmp;
  logic        irq;
  int          cmp_mode = 0;

  int checks = 0;
  int errors = 0;

`ifdef DELAY_SWEEP_IRQ_EN
  localparam logic [31:0] IRQ_BIT = 32'h4;
`else
  localparam logic [31:0] IRQ_BIT = 32'h0;
`endif

  always #5 clk = ~clk;

  delay_sweep_ctrl dut (
    .wb_clk_i     (clk),
    .wb_rst_i     (rst),
    .wb_adr_i     (adr),
    .wb_dat_i     (dat_i),
    .wb_dat_o     (dat_o),
    .wb_we_i      (we),
    .wb_sel_i     (sel),
    .wb_cyc_i     (cyc),
    .wb_stb_i     (stb),
    .wb_ack_o     (ack),
    .wb_stall_o   (stall),
    .wb_err_o     (err),
    .delay_code_o (code),
    .delay_stb_o  (dstb),
    .cmp_out_i    (cmp)
`ifdef DELAY_SWEEP_IRQ_EN
    ,
    .irq_o        (irq)
`endif
  );
`ifndef DELAY_SWEEP_IRQ_EN
  assign irq = 1'b0;
`endif

  // Strobe monitor: logs the code of every strobe and counts strobes per code.
  logic [9:0] stb_codes[$];
  logic [9:0] mon_code = '0;
  logic       mon_stb = 1'b0;
  int         stb_cnt = 0;

  always @(negedge clk) begin
    if (code != mon_code) begin
      mon_code <= code;
      stb_cnt  <= 0;
    end else if (dstb && !mon_stb) begin
      stb_cnt  <= stb_cnt + 1;
    end
    if (dstb && !mon_stb) stb_codes.push_back(code);
    mon_stb <= dstb;
  end

  assign cmp = (cmp_mode == 1) ? (code >= 10'd2) :
               (cmp_mode == 2) ? ((code == 10'd7 && stb_cnt >= 1 && stb_cnt <= 3) ||
                                  (code == 10'd6 && stb_cnt >= 1 && stb_cnt <= 2)) :
               1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wb_xfer(input logic w, input logic [2:0] word, input logic [31:0] wd,
                         output logic [31:0] rd);
    int t;
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = w; adr = {27'd0, word, 2'b00}; dat_i = wd;
    t = 0;
    do begin
      @(posedge clk); #1; t++;
    end while (!ack && t < 8);
    chk("wb_ack", {31'd0, ack}, 32'd1);
    rd = dat_o;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    $display("WB %s word=%0d wdata=0x%08h rdata=0x%08h", w ? "WR" : "RD", word, wd, rd);
  endtask

  task automatic wb_wr(input logic [2:0] word, input logic [31:0] wd);
    logic [31:0] dummy;
    wb_xfer(1'b1, word, wd, dummy);
  endtask

  task automatic wb_rd(input logic [2:0] word, output logic [31:0] rd);
    wb_xfer(1'b0, word, 32'd0, rd);
  endtask

  task automatic rd_chk(input string tag, input logic [2:0] word, input logic [31:0] exp);
    logic [31:0] r;
    wb_rd(word, r);
    chk(tag, r, exp);
  endtask

  task automatic wait_done();
    logic [31:0] r;
    int n;
    n = 0;
    do begin
      wb_rd(REG_STATUS, r); n++;
    end while (!r[1] && n < 100);
    chk("done_seen", {31'd0, r[1]}, 32'd1);
  endtask

  initial begin
    logic [31:0] r;
    logic        saw;
    int          n;

    // Reset state
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_code", {22'd0, code}, 32'd0);
    chk("rst_stb", {31'd0, dstb}, 32'd0);
    chk("rst_ack", {31'd0, ack}, 32'd0);
    chk("rst_dat", dat_o, 32'd0);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    rd_chk("rst_status", REG_STATUS, 32'd0);
    rd_chk("rst_result", REG_RESULT, 32'd0);
    rd_chk("rst_hits", REG_HITS, 32'd0);
    rd_chk("rst_reps", REG_REPS, 32'd0);
    rd_chk("rst_ctrl", REG_CTRL, 32'd0);
    @(posedge clk); #1;
    chk("ack_one_cycle", {31'd0, ack}, 32'd0);

    wb_wr(REG_CTRL, 32'h4);
    rd_chk("ctrl_irq_en", REG_CTRL, IRQ_BIT);

    // Basic sweep, probe one cycle before DONE
    cmp_mode = 1;
    wb_wr(REG_START_CODE, 32'd0);
    wb_wr(REG_STOP_STEP, 32'h0001_0003);
    wb_wr(REG_REPS, 32'd4);
    stb_codes.delete();
    wb_wr(REG_CTRL, 32'h5);
    repeat (115) @(posedge clk);
    rd_chk("basic_status_116", REG_STATUS, 32'h0003_0005);
    repeat (5) @(posedge clk);
    rd_chk("basic_status_end", REG_STATUS, 32'h0003_0006);
    rd_chk("basic_result", REG_RESULT, 32'd2);
    rd_chk("basic_hits", REG_HITS, 32'd4);
    chk("basic_nstb", stb_codes.size(), 32'd16);
    chk("basic_stb_first", {22'd0, stb_codes[0]}, 32'd0);
    chk("basic_stb_last", {22'd0, stb_codes[15]}, 32'd3);
`ifdef DELAY_SWEEP_IRQ_EN
    chk("irq_high", {31'd0, irq}, 32'd1);
`endif
    wb_wr(REG_STATUS, 32'h2);
`ifdef DELAY_SWEEP_IRQ_EN
    chk("irq_in_ack", {31'd0, irq}, 32'd1);
    @(posedge clk); #1;
    chk("irq_cleared", {31'd0, irq}, 32'd0);
`endif
    rd_chk("basic_done_clr", REG_STATUS, 32'h0003_0004);

    // Same sweep, probe exactly 117 cycles after START ack
    wb_wr(REG_CTRL, 32'h5);
    repeat (116) @(posedge clk);
    rd_chk("basic_status_117", REG_STATUS, 32'h0003_0006);
    wb_wr(REG_STATUS, 32'h2);

    // No edge; START and config write while busy are ignored for this run
    cmp_mode = 0;
    wb_wr(REG_START_CODE, 32'd10);
    wb_wr(REG_STOP_STEP, 32'h0005_0014);
    wb_wr(REG_REPS, 32'd2);
    stb_codes.delete();
    wb_wr(REG_CTRL, 32'h5);
    repeat (10) @(posedge clk);
    wb_wr(REG_CTRL, 32'h5);
    wb_wr(REG_STOP_STEP, 32'h0005_0001);
    wait_done();
    chk("noedge_nstb", stb_codes.size(), 32'd6);
    chk("noedge_c0", {22'd0, stb_codes[0]}, 32'd10);
    chk("noedge_c1", {22'd0, stb_codes[2]}, 32'd15);
    chk("noedge_c2", {22'd0, stb_codes[4]}, 32'd20);
    rd_chk("noedge_status", REG_STATUS, 32'h0014_0002);
    rd_chk("noedge_result", REG_RESULT, 32'd0);
    rd_chk("noedge_hits", REG_HITS, 32'd0);
    rd_chk("noedge_stop_rb", REG_STOP_STEP, 32'h0005_0001);
    wb_wr(REG_STATUS, 32'h2);

    // Overflow with STEP=0, REPS=0
    wb_wr(REG_START_CODE, 32'h3FE);
    wb_wr(REG_STOP_STEP, 32'h0000_03FF);
    wb_wr(REG_REPS, 32'd0);
    stb_codes.delete();
    wb_wr(REG_CTRL, 32'h5);
    wait_done();
    chk("ovf_nstb", stb_codes.size(), 32'd2);
    chk("ovf_c0", {22'd0, stb_codes[0]}, 32'h3FE);
    chk("ovf_c1", {22'd0, stb_codes[1]}, 32'h3FF);
    rd_chk("ovf_status", REG_STATUS, 32'h03FF_0002);
    wb_wr(REG_STATUS, 32'h2);

    // Large step overflows after the first code
    wb_wr(REG_START_CODE, 32'h3F0);
    wb_wr(REG_STOP_STEP, 32'h0020_03FF);
    stb_codes.delete();
    wb_wr(REG_CTRL, 32'h5);
    wait_done();
    chk("bigstep_nstb", stb_codes.size(), 32'd1);
    chk("bigstep_c0", {22'd0, stb_codes[0]}, 32'h3F0);
    wb_wr(REG_STATUS, 32'h2);

    // START_CODE > STOP_CODE runs one code
    wb_wr(REG_START_CODE, 32'd5);
    wb_wr(REG_STOP_STEP, 32'h0001_0002);
    stb_codes.delete();
    wb_wr(REG_CTRL, 32'h5);
    wait_done();
    chk("rev_nstb", stb_codes.size(), 32'd1);
    chk("rev_c0", {22'd0, stb_codes[0]}, 32'd5);
    wb_wr(REG_STATUS, 32'h2);

    // Majority threshold: 2/5 at code 6, 3/5 at code 7
    cmp_mode = 2;
    wb_wr(REG_START_CODE, 32'd6);
    wb_wr(REG_STOP_STEP, 32'h0001_0007);
    wb_wr(REG_REPS, 32'd5);
    wb_wr(REG_CTRL, 32'h5);
    wait_done();
    rd_chk("maj_result", REG_RESULT, 32'd7);
    rd_chk("maj_hits", REG_HITS, 32'd3);
    rd_chk("maj_status", REG_STATUS, 32'h0007_0006);
    wb_wr(REG_STATUS, 32'h2);

    // Abort during STB_HI
    cmp_mode = 1;
    wb_wr(REG_START_CODE, 32'd0);
    wb_wr(REG_STOP_STEP, 32'h0001_0003);
    wb_wr(REG_REPS, 32'd4);
    wb_wr(REG_CTRL, 32'h5);
    n = 0;
    while (!dstb && n < 60) begin
      @(posedge clk); #1; n++;
    end
    chk("abort_stb_seen", {31'd0, dstb}, 32'd1);
    wb_wr(REG_CTRL, 32'h6);
    @(posedge clk); #1;
    chk("abort_stb_low", {31'd0, dstb}, 32'd0);
    saw = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
      if (dstb) saw = 1'b1;
    end
    chk("abort_stb_quiet", {31'd0, saw}, 32'd0);
    wb_rd(REG_STATUS, r);
    chk("abort_busy_done", r & 32'h3, 32'd0);

    // START and ABORT together: nothing starts
    wb_wr(REG_CTRL, 32'h7);
    wb_rd(REG_STATUS, r);
    chk("start_abort_busy", r & 32'h1, 32'd0);

    // Full sweep after abort
    stb_codes.delete();
    wb_wr(REG_CTRL, 32'h5);
    wait_done();
    rd_chk("rerun_result", REG_RESULT, 32'd2);
    rd_chk("rerun_hits", REG_HITS, 32'd4);
    rd_chk("rerun_status", REG_STATUS, 32'h0003_0006);
    chk("rerun_nstb", stb_codes.size(), 32'd16);

    // Mid-sweep reset (DONE left set so irq is high if present)
    wb_wr(REG_CTRL, 32'h5);
    repeat (40) @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("mrst_code", {22'd0, code}, 32'd0);
    chk("mrst_stb", {31'd0, dstb}, 32'd0);
    chk("mrst_irq", {31'd0, irq}, 32'd0);
    rst = 1'b0;
    chk("mrst_ack", {31'd0, ack}, 32'd0);
    chk("mrst_dat", dat_o, 32'd0);
    rd_chk("mrst_status", REG_STATUS, 32'd0);
    rd_chk("mrst_result", REG_RESULT, 32'd0);
    rd_chk("mrst_hits", REG_HITS, 32'd0);
    rd_chk("mrst_stop", REG_STOP_STEP, 32'd0);
    rd_chk("mrst_ctrl", REG_CTRL, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
